// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, coordinate width and axis-length helper
// for the VGA raster generator.
package vga_timing_pkg;

  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_SYNC_POL  = 0;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, plus visible/sync decode of the
// value the counter will hold after the current edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               advance,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               next_active,
  output logic               next_sync
);

  localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

  // Compare in one extra bit so bounds equal to 1024 do not alias to zero.
  localparam logic [COORD_W:0] LAST       = (COORD_W+1)'(TOTAL - 1);
  localparam logic [COORD_W:0] VIS_END    = (COORD_W+1)'(VISIBLE);
  localparam logic [COORD_W:0] SYNC_START = (COORD_W+1)'(VISIBLE + FRONT);
  localparam logic [COORD_W:0] SYNC_END   = (COORD_W+1)'(VISIBLE + FRONT + SYNC);

  logic [COORD_W-1:0] count_next;
  logic [COORD_W:0]   count_ext;

  // Next position: wrap at the end of the axis, reset forces the origin.
  always_comb begin
    wrap       = 1'b0;
    count_next = count;
    if (advance && ({1'b0, count} == LAST)) begin
      wrap = 1'b1;
    end else begin
      wrap = 1'b0;
    end
    if (Reset) begin
      count_next = '0;
    end else if (wrap) begin
      count_next = '0;
    end else if (advance) begin
      count_next = count + COORD_W'(1);
    end else begin
      count_next = count;
    end
  end

  assign count_ext   = {1'b0, count_next};
  assign next_active = (count_ext < VIS_END);
  assign next_sync   = (count_ext >= SYNC_START) && (count_ext < SYNC_END);

  // Position register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-rate divider, H/V position counters, sync pins and
// pixel/line/frame strobes. Define VGA_SYNC_PIPE_EN to delay syncs and display-area by one Clk.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int SYNC_POL  = DEF_SYNC_POL
) (
  input  logic               Clk,
  input  logic               Reset,
  output logic [COORD_W-1:0] CounterX,
  output logic [COORD_W-1:0] CounterY,
  output logic               inDisplayArea,
  output logic               vga_h_sync,
  output logic               vga_v_sync,
  output logic               PixelTick,
  output logic               LineTick,
  output logic               FrameTick
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int DIV_W   = 4;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] V_VIS_LAST = COORD_W'(V_VISIBLE - 1);
  localparam logic               SYNC_ACT   = (SYNC_POL != 0);

  if (H_TOTAL > MAX_TOTAL) begin : g_h_total_err
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_v_total_err
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_div_err
    $error("vga_timing_gen: CLK_DIV must be 1..16");
  end

  logic [DIV_W-1:0] div_cnt;
  logic h_wrap, v_wrap_unused, v_advance;
  logic h_next_active, h_next_sync, v_next_active, v_next_sync;
  logic disp_s1, hs_s1, vs_s1;
  logic line_tick_r, frame_tick_r;
  logic frame_next;

  // With CLK_DIV==1 DIV_LAST is 0, so the decode is constantly 1.
  assign PixelTick = (div_cnt == DIV_LAST);

  // Pixel-rate divider; wraps on its own terminal count.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt <= '0;
    end else if (PixelTick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign v_advance = h_wrap;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .Clk         (Clk),
    .Reset       (Reset),
    .advance     (PixelTick),
    .count       (CounterX),
    .wrap        (h_wrap),
    .next_active (h_next_active),
    .next_sync   (h_next_sync)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .Clk         (Clk),
    .Reset       (Reset),
    .advance     (v_advance),
    .count       (CounterY),
    .wrap        (v_wrap_unused),
    .next_active (v_next_active),
    .next_sync   (v_next_sync)
  );

  // Start of vertical blank: the line wrap that moves CounterY onto V_VISIBLE.
  assign frame_next = h_wrap && (CounterY == V_VIS_LAST);

  // Flags registered from next-state positions so they line up with CounterX/Y.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      disp_s1      <= 1'b1;
      hs_s1        <= ~SYNC_ACT;
      vs_s1        <= ~SYNC_ACT;
      line_tick_r  <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      disp_s1      <= h_next_active && v_next_active;
      hs_s1        <= h_next_sync ? SYNC_ACT : ~SYNC_ACT;
      vs_s1        <= v_next_sync ? SYNC_ACT : ~SYNC_ACT;
      line_tick_r  <= h_wrap;
      frame_tick_r <= frame_next;
    end
  end

  assign LineTick  = line_tick_r;
  assign FrameTick = frame_tick_r;

`ifdef VGA_SYNC_PIPE_EN
  logic disp_s2, hs_s2, vs_s2;

  // Extra stage matching the registered RGB path of the drawing logic.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      disp_s2 <= 1'b1;
      hs_s2   <= ~SYNC_ACT;
      vs_s2   <= ~SYNC_ACT;
    end else begin
      disp_s2 <= disp_s1;
      hs_s2   <= hs_s1;
      vs_s2   <= vs_s1;
    end
  end

  assign inDisplayArea = disp_s2;
  assign vga_h_sync    = hs_s2;
  assign vga_v_sync    = vs_s2;
`else
  assign inDisplayArea = disp_s1;
  assign vga_h_sync    = hs_s1;
  assign vga_v_sync    = vs_s1;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for pixel/line timing and a tiny
// CLK_DIV=1, active-high-sync instance for multi-frame behaviour.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic       Clk;
  logic       Reset;
  logic [9:0] CounterX, CounterY;
  logic       inDisplayArea, vga_h_sync, vga_v_sync, PixelTick, LineTick, FrameTick;

  logic       s_reset;
  logic [9:0] s_x, s_y;
  logic       s_disp, s_hs, s_vs, s_pix, s_lt, s_ft;

  int n_checks;
  int n_fail;

  vga_timing_gen u_dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .CounterX      (CounterX),
    .CounterY      (CounterY),
    .inDisplayArea (inDisplayArea),
    .vga_h_sync    (vga_h_sync),
    .vga_v_sync    (vga_v_sync),
    .PixelTick     (PixelTick),
    .LineTick      (LineTick),
    .FrameTick     (FrameTick)
  );

  // 16 x 12 raster: h sync 10..12, v sync lines 8..9, frame = 192 Clk.
  vga_timing_gen #(
    .CLK_DIV   (1),
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (2),
    .SYNC_POL  (1)
  ) u_small (
    .Clk           (Clk),
    .Reset         (s_reset),
    .CounterX      (s_x),
    .CounterY      (s_y),
    .inDisplayArea (s_disp),
    .vga_h_sync    (s_hs),
    .vga_v_sync    (s_vs),
    .PixelTick     (s_pix),
    .LineTick      (s_lt),
    .FrameTick     (s_ft)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  int hs_low, hs_fall_t, hs_fall_x, disp_fall_t, disp_fall_x, lt_cnt;
  logic prev_hs, prev_disp;
  int ft_cnt, ft_first, ft_second, s_lt_cnt, y_wraps, vs_cnt, vs_bad, x_bad, pix_bad;
  logic [9:0] prev_y, y_ref;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    s_reset  = 1'b1;
    step(5);

    // Reset state
    check_val("rst_x",     CounterX, 0);
    check_val("rst_y",     CounterY, 0);
    check_val("rst_disp",  inDisplayArea, 1);
    check_val("rst_hs",    vga_h_sync, 1);
    check_val("rst_vs",    vga_v_sync, 1);
    check_val("rst_pix",   PixelTick, 0);
    check_val("rst_lt",    LineTick, 0);
    check_val("rst_ft",    FrameTick, 0);
    check_val("s_rst_pix", s_pix, 1);
    check_val("s_rst_hs",  s_hs, 0);
    check_val("s_rst_vs",  s_vs, 0);
    check_val("s_rst_disp", s_disp, 1);

    // Release: X advances every second Clk
    Reset = 1'b0;
    step(1);
    check_val("t1_x",   CounterX, 0);
    check_val("t1_pix", PixelTick, 1);
    step(1);
    check_val("t2_x",   CounterX, 1);
    check_val("t2_pix", PixelTick, 0);
    step(1597);
    check_val("t1599_x",  CounterX, 799);
    check_val("t1599_y",  CounterY, 0);
    check_val("t1599_lt", LineTick, 0);
    step(1);
    check_val("t1600_x",  CounterX, 0);
    check_val("t1600_y",  CounterY, 1);
    check_val("t1600_lt", LineTick, 1);
    step(1);
    check_val("t1601_lt", LineTick, 0);
    check_val("t1601_x",  CounterX, 0);

    // Monitor line 1 (t = 1602..3201)
    prev_hs = vga_h_sync; prev_disp = inDisplayArea;
    hs_low = 0; lt_cnt = 0;
    hs_fall_t = -1; hs_fall_x = -1; disp_fall_t = -1; disp_fall_x = -1;
    for (int t = 1602; t <= 3201; t++) begin
      step(1);
      if (!vga_h_sync) hs_low++;
      if (prev_hs && !vga_h_sync) begin hs_fall_t = t; hs_fall_x = CounterX; end
      if (prev_disp && !inDisplayArea) begin disp_fall_t = t; disp_fall_x = CounterX; end
      if (LineTick) lt_cnt++;
      prev_hs = vga_h_sync;
      prev_disp = inDisplayArea;
    end
    check_val("hs_low_clks", hs_low, 192);
    check_val("hs_fall_t",   hs_fall_t, 2912 + PIPE);
    check_val("hs_fall_x",   hs_fall_x, 656);
    check_val("disp_fall_t", disp_fall_t, 2880 + PIPE);
    check_val("disp_fall_x", disp_fall_x, 640);
    check_val("line_lt_cnt", lt_cnt, 1);

    // One-Clk reset at (300,2)
    step(599);
    check_val("pre_rst_x", CounterX, 300);
    check_val("pre_rst_y", CounterY, 2);
    Reset = 1'b1;
    step(1);
    check_val("mid_rst_x",  CounterX, 0);
    check_val("mid_rst_y",  CounterY, 0);
    check_val("mid_rst_hs", vga_h_sync, 1);
    check_val("mid_rst_vs", vga_v_sync, 1);
    check_val("mid_rst_lt", LineTick, 0);
    Reset = 1'b0;
    step(1);
    check_val("post_rst_x",  CounterX, 0);
    check_val("post_rst_lt", LineTick, 0);
    check_val("post_rst_ft", FrameTick, 0);
    check_val("post_rst_hs", vga_h_sync, 1);
    step(1);
    check_val("post_rst2_x", CounterX, 1);

    // Small raster: two full frames
    s_reset = 1'b0;
    prev_y = s_y;
    ft_cnt = 0; ft_first = -1; ft_second = -1; s_lt_cnt = 0; y_wraps = 0;
    vs_cnt = 0; vs_bad = 0; x_bad = 0; pix_bad = 0;
    for (int s = 1; s <= 384; s++) begin
      step(1);
      if (s_ft) begin
        ft_cnt++;
        if (ft_first < 0) ft_first = s;
        else ft_second = s;
      end
      if (s_lt) s_lt_cnt++;
      if (prev_y == 10'd11 && s_y == 10'd0) y_wraps++;
      y_ref = (PIPE != 0) ? prev_y : s_y;
      if (s_vs) begin
        vs_cnt++;
        if (y_ref < 10'd8 || y_ref > 10'd9) vs_bad++;
      end
      if (int'(s_x) != (s % 16)) x_bad++;
      if (!s_pix) pix_bad++;
      prev_y = s_y;
    end
    check_val("s_ft_cnt",    ft_cnt, 2);
    check_val("s_ft_first",  ft_first, 96);
    check_val("s_ft_second", ft_second, 288);
    check_val("s_lt_cnt",    s_lt_cnt, 24);
    check_val("s_y_wraps",   y_wraps, 2);
    check_val("s_vs_cnt",    vs_cnt, 64);
    check_val("s_vs_bad",    vs_bad, 0);
    check_val("s_x_bad",     x_bad, 0);
    check_val("s_pix_bad",   pix_bad, 0);

    // Reset beats a pending line wrap
    step(15);
    check_val("s_pre_x", s_x, 15);
    s_reset = 1'b1;
    step(1);
    check_val("s_rst_x",  s_x, 0);
    check_val("s_rst_lt", s_lt, 0);
    s_reset = 1'b0;
    step(1);
    check_val("s_rel_x",  s_x, 1);
    check_val("s_rel_y",  s_y, 0);
    check_val("s_rel_lt", s_lt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
